regbank_rr_arbiter: RTL and testbench
=====================================

// Module: regbank_rr_arbiter
// PURPOSE
//  Shares one bank of DEPTH flip-flop registers (WIDTH bits each) between
//  NREQ requesters. Each requester holds req to ask for one read or write.
//  A round-robin arbiter picks one requester and serves it, and the block
//  returns a one-cycle ack. This is the access controller in front of the
//  register storage: it is the only path that writes or reads the bank.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  WIDTH  8  data bits per register
//  DEPTH  8  number of registers in the bank
//  AW     3  address width; DEPTH <= 2**AW
// PORTS
//  clk    in   1           clock; all state updates on posedge
//  rst    in   1           synchronous reset, active-high
//  req    in   NREQ        req[i]=1: requester i wants an access
//  we     in   NREQ        we[i]=1 write, 0 read; sampled at grant
//  addr   in   NREQ*AW     addr[i*AW +: AW], register index for requester i
//  wdata  in   NREQ*WIDTH  wdata[i*WIDTH +: WIDTH], write data for requester i
//  gnt    out  NREQ        registered one-hot grant; all zeros when idle
//  ack    out  1           one-cycle pulse when the granted access completes
//  rdata  out  WIDTH       read result; valid while ack=1, held until next read
//  busy   out  1           1 while state=SERVE
// BEHAVIOUR
//  Reset (rst=1 at a posedge):
//   - gnt=0, ack=0, rdata=0, busy=0, state=IDLE, rr_ptr=0.
//   - All DEPTH bank registers are cleared to 0.
//   - Reset overrides every other event in the same cycle.
//  FSM has two states, IDLE and SERVE:
//   - IDLE, req!=0: pick the winner w, the first i with req[i]=1 when
//     scanning rr_ptr, rr_ptr+1, ... modulo NREQ. Latch we[w], addr[w] and
//     wdata[w]. Set gnt=onehot(w) and busy=1. Next state is SERVE.
//   - IDLE, req==0: stay in IDLE with gnt=0.
//   - SERVE: do the latched access. A write sets bank[a]<=d. A read sets
//     rdata<=bank[a]. Set ack=1 for this one cycle and hold gnt.
//     Set rr_ptr<=(w+1)%NREQ. Next state is IDLE; gnt and busy drop next cycle.
//  Latency and throughput:
//   - From req sampled in IDLE, gnt shows 1 cycle later and ack 2 cycles later.
//   - Maximum rate is one access per 2 cycles.
//  Handshake:
//   - A requester holds req, we, addr and wdata until it sees ack.
//   - A request is committed at grant. If req drops during SERVE, the
//     access still completes and ack still pulses.
//   - Requesters deassert req in the ack cycle. If req[i] is still 1 in
//     the following IDLE cycle, it is a new request.
//  Fairness:
//   - The winner gets the lowest priority in the next arbitration.
//   - With all NREQ requests held, every requester is served once within
//     NREQ transactions.
//  Boundary conditions:
//   - Address >= DEPTH: a write does nothing to the bank; a read returns 0.
//     ack still pulses.
//   - Write followed by read of the same address: the read returns the
//     new value. The bank has no forwarding hazard.
//   - rdata is updated only by reads; a write leaves rdata unchanged.
//   - rst during SERVE: the access is aborted, no bank write, no ack.
//   - Inputs of requesters that are not granted are ignored.
// TESTING
//  1. Hold rst=1 for 2 cycles, then release -> gnt=0, ack=0, rdata=0;
//     reading addr 0..7 returns 0.
//  2. Only req[2], we=1, addr=5, wdata=8'hA5 -> gnt=4'b0100 at +1,
//     ack at +2. Then req[2] read addr 5 -> rdata=8'hA5 with ack.
//  3. req=4'b1111 held, all reads, from reset -> grants in order
//     0,1,2,3,0, one ack every 2 cycles.
//  4. After req[1] is served, req=4'b0011 -> req[0] wins, because
//     rr_ptr=2 wraps to 0 before 1.
//  5. Write addr 9 with DEPTH=8, AW=4 -> ack pulses and the bank is
//     unchanged. Reading addr 9 returns 0.
//  6. req[3] write 8'h3C, then rst=1 in the SERVE cycle -> no ack,
//     bank[addr]=0, gnt=0 on the next cycle.

Source files
------------

// File: rtl/regbank_rr_arbiter.sv
// Round-robin access controller in front of a DEPTH x WIDTH flip-flop register bank.
// One requester is granted per transaction; the access is committed at grant and completed one cycle later.
module regbank_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  ack,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     win;
  logic [NREQ-1:0]   gnt_nxt;
  logic              busy_nxt;
  logic              ack_nxt;
  logic              latch;
  logic              serve;

  logic              we_p1;
  logic [AW-1:0]     addr_p1;
  logic [WIDTH-1:0]  wdata_p1;
  logic [PW-1:0]     idx_p1;
  logic              in_range_p1;
  logic [IW-1:0]     bidx_p1;
  logic [PW-1:0]     ptr_after;

  logic [WIDTH-1:0]  bank [DEPTH];

  // First requester at or after the pointer, scanning modulo NREQ.
  function automatic logic [PW-1:0] pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] w;
    logic          found;
    int            idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!found && r[idx]) begin
        w     = PW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign win         = pick(req, rr_ptr);
  assign in_range_p1 = ({1'b0, addr_p1} < DEPTH_L);
  assign bidx_p1     = addr_p1[IW-1:0];
  assign ptr_after   = (int'(idx_p1) == NREQ - 1) ? '0 : idx_p1 + 1'b1;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = '0;
    busy_nxt  = 1'b0;
    ack_nxt   = 1'b0;
    latch     = 1'b0;
    serve     = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt    = SERVE;
          gnt_nxt[win] = 1'b1;
          busy_nxt     = 1'b1;
          latch        = 1'b1;
        end
      end
      SERVE: begin
        state_nxt = IDLE;
        ack_nxt   = 1'b1;
        serve     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      busy   <= 1'b0;
      ack    <= 1'b0;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
      ack   <= ack_nxt;
      if (serve) rr_ptr <= ptr_after;
    end
  end

  // Stage p1: winner's request captured at grant; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (latch) begin
      we_p1    <= we[win];
      addr_p1  <= addr[int'(win)*AW +: AW];
      wdata_p1 <= wdata[int'(win)*WIDTH +: WIDTH];
      idx_p1   <= win;
    end
  end

  // Stage p2: bank access; out-of-range writes are dropped and reads return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      rdata <= '0;
    end else if (serve) begin
      if (we_p1) begin
        if (in_range_p1) bank[bidx_p1] <= wdata_p1;
      end else begin
        rdata <= in_range_p1 ? bank[bidx_p1] : '0;
      end
    end
  end

endmodule

// File: tb/tb_regbank_rr_arbiter.sv
// Directed bench for regbank_rr_arbiter (NREQ=4, WIDTH=8, DEPTH=8, AW=4).
module tb_regbank_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  we = '0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic        ack;
  logic [7:0]  rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  regbank_rr_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(8), .AW(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One solo access by requester i, checking grant, ack pulse and rdata.
  task automatic access(input int i, input logic w, input int a, input logic [7:0] d,
                        input logic [7:0] exp_rd);
    req = '0;
    req[i] = 1'b1;
    we[i] = w;
    addr[i*4 +: 4] = a[3:0];
    wdata[i*8 +: 8] = d;
    cyc();
    chk("gnt", {28'd0, gnt}, 32'd1 << i);
    chk("busy", {31'd0, busy}, 32'd1);
    chk("ack_early", {31'd0, ack}, 32'd0);
    cyc();
    chk("ack", {31'd0, ack}, 32'd1);
    chk("gnt_drop", {28'd0, gnt}, 32'd0);
    chk("rdata", {24'd0, rdata}, {24'd0, exp_rd});
    req = '0;
    cyc();
    chk("ack_pulse", {31'd0, ack}, 32'd0);
  endtask

  initial begin
    // 1: reset state and cleared bank
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    for (int a = 0; a < 8; a++) access(0, 1'b0, a, 8'h00, 8'h00);

    // 2: write then read back through requester 2
    access(2, 1'b1, 5, 8'hA5, 8'h00);
    access(2, 1'b0, 5, 8'h00, 8'hA5);

    // 3: all requesters held from reset, reads
    rst = 1'b1;
    req = '0;
    cyc();
    cyc();
    rst = 1'b0;
    we = '0;
    addr = '0;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      cyc();
      chk("rr_gnt", {28'd0, gnt}, 32'd1 << (t % 4));
      chk("rr_ack_lo", {31'd0, ack}, 32'd0);
      cyc();
      chk("rr_ack_hi", {31'd0, ack}, 32'd1);
      chk("rr_gnt_lo", {28'd0, gnt}, 32'd0);
    end
    req = '0;
    cyc();
    chk("rr_idle", {28'd0, gnt}, 32'd0);

    // 4: pointer wraps past 3 to 0 before reaching 1
    access(1, 1'b1, 1, 8'h11, 8'h00);
    we = '0;
    addr = 16'h0021;
    req = 4'b0011;
    cyc();
    chk("wrap_gnt0", {28'd0, gnt}, 32'd1);
    cyc();
    chk("wrap_ack0", {31'd0, ack}, 32'd1);
    chk("wrap_rd0", {24'd0, rdata}, 32'h11);
    req = 4'b0010;
    cyc();
    chk("wrap_gnt1", {28'd0, gnt}, 32'd2);
    cyc();
    chk("wrap_ack1", {31'd0, ack}, 32'd1);
    chk("wrap_rd1", {24'd0, rdata}, 32'h00);
    req = '0;
    cyc();

    // 5: out-of-range address
    access(0, 1'b0, 1, 8'h00, 8'h11);
    access(0, 1'b1, 9, 8'hFF, 8'h11);
    access(0, 1'b0, 1, 8'h00, 8'h11);
    access(0, 1'b0, 9, 8'h00, 8'h00);
    access(0, 1'b0, 1, 8'h00, 8'h11);

    // 6: reset during SERVE aborts the write
    req = 4'b1000;
    we = 4'b1000;
    addr = 16'h6000;
    wdata = 32'h3C00_0000;
    cyc();
    chk("abort_gnt", {28'd0, gnt}, 32'h8);
    rst = 1'b1;
    req = '0;
    cyc();
    chk("abort_ack", {31'd0, ack}, 32'd0);
    chk("abort_gnt0", {28'd0, gnt}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    cyc();
    chk("abort_noack", {31'd0, ack}, 32'd0);
    we = '0;
    req = 4'b1111;
    cyc();
    chk("ptr_reset_gnt", {28'd0, gnt}, 32'd1);
    cyc();
    chk("ptr_reset_ack", {31'd0, ack}, 32'd1);
    req = '0;
    cyc();
    access(3, 1'b0, 6, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
